// File: rtl/aurora_bus_if.sv
// ============================================================================
//  Module   : aurora_bus_if
//  Purpose  : Aurora FPGA local bus signal bundle (requests, grants, stb/we
//             and slave handshake) shared by the arbiter and the bus side.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aurora_bus_if;
    logic req_w_1;
    logic req_w_2;
    logic req_r_1;
    logic req_r_2;
    logic gnt_w_1;
    logic gnt_w_2;
    logic gnt_r_1;
    logic gnt_r_2;
    logic stb;
    logic we;
    logic ack;
    logic m_rdy;
    logic s_rdy;
    logic abort;

    modport master (
        input  req_w_1, req_w_2, req_r_1, req_r_2,
        input  ack, m_rdy, s_rdy, abort,
        output gnt_w_1, gnt_w_2, gnt_r_1, gnt_r_2,
        output stb, we
    );

    modport slave (
        output req_w_1, req_w_2, req_r_1, req_r_2,
        output ack, m_rdy, s_rdy, abort,
        input  gnt_w_1, gnt_w_2, gnt_r_1, gnt_r_2,
        input  stb, we
    );
endinterface

`default_nettype wire

// File: rtl/aurora_bus_arbiter.sv
// ============================================================================
//  Module   : aurora_bus_arbiter
//  Purpose  : Round-robin arbiter and burst sequencer for the Aurora local bus
//             (two write and two read requesters, beat/timeout counting).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aurora_bus_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1024
) (
    input  wire              clk,
    input  wire              rst_n,
    aurora_bus_if.master     bus,
    output logic             beat,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             busy,
    output logic             done_p,
    output logic             abort_p,
    output logic             timeout_p
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_BURST   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit               C_TO_EN   = (TIMEOUT != 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       w_win;
    logic [3:0]       w_req;
    logic             w_grant_en;
    logic             w_beat_raw;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_beat_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] r_to_cnt;
    logic [CNT_W-1:0] w_to_cnt_nxt;
    logic [CNT_W-1:0] w_to_inc;

    // Requester index: 0=w1, 1=w2, 2=r1, 3=r2; bit 1 set means a read.
    assign w_req = {bus.req_r_2, bus.req_r_1, bus.req_w_2, bus.req_w_1};

    // Scan from r_ptr upward; the lowest offset with a request wins.
    always_comb begin
        w_win = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (w_req[r_ptr + 2'(i)]) begin
                w_win = r_ptr + 2'(i);
            end
        end
    end

    assign w_cnt_inc  = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + CNT_W'(1);
    assign w_to_inc   = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + CNT_W'(1);
    assign w_beat_raw = r_sel[1] ? bus.s_rdy : (bus.m_rdy & bus.ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel      <= 2'd0;
            r_ptr      <= 2'd0;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        beat           = 1'b0;
        done_p         = 1'b0;
        abort_p        = 1'b0;
        timeout_p      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_sel_nxt   = w_win;
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                w_beat_cnt_nxt = '0;
                w_to_cnt_nxt   = '0;
                w_state_nxt    = S_XFER;
            end
            S_XFER: begin
                beat = w_beat_raw;
                if (w_beat_raw) begin
                    w_beat_cnt_nxt = w_cnt_inc;
                    w_to_cnt_nxt   = '0;
                end else begin
                    w_to_cnt_nxt   = w_to_inc;
                end
                // Every exit moves the pointer past the served requester.
                if (bus.abort) begin
                    abort_p     = 1'b1;
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_state_nxt = S_IDLE;
                end else if (w_beat_raw && (w_cnt_inc == C_BURST)) begin
                    done_p      = 1'b1;
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_state_nxt = S_DONE;
                end else if (!w_req[r_sel]) begin
                    done_p      = 1'b1;
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_state_nxt = S_DONE;
                end else if (C_TO_EN && !w_beat_raw && (r_to_cnt == C_TO_LAST)) begin
                    timeout_p   = 1'b1;
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_grant_en  = (r_state == S_ARB) || (r_state == S_XFER);
    assign bus.gnt_w_1 = w_grant_en && (r_sel == 2'd0);
    assign bus.gnt_w_2 = w_grant_en && (r_sel == 2'd1);
    assign bus.gnt_r_1 = w_grant_en && (r_sel == 2'd2);
    assign bus.gnt_r_2 = w_grant_en && (r_sel == 2'd3);
    assign bus.stb     = (r_state == S_XFER);
    assign bus.we      = w_grant_en && !r_sel[1];
    assign busy        = (r_state != S_IDLE);
    assign beat_cnt    = r_beat_cnt;

endmodule

`default_nettype wire
